// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I-subset core with one shared req/ready memory port.
// Each instruction steps through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK; faults park in HALT.
module multicycle_datapath #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  input  logic                 mem_ready,
  output logic [XLEN-1:0]      pc,
  output logic                 halted,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [1:0] TrapIllegal   = 2'd1;
  localparam logic [1:0] TrapDataAlign = 2'd2;
  localparam logic [1:0] TrapJumpAlign = 2'd3;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExecute,
    StMemory,
    StWriteback,
    StHalt
  } state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [31:0]            ir_q, ir_d;
  logic [XLEN-1:0]        a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [XLEN-1:0]        aluout_q, aluout_d, mdr_q, mdr_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic [1:0]             trap_q, trap_d;
  logic [XLEN-1:0]        rf_q [32];

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic            is_reg, is_imm, is_lw, is_sw, is_br, is_jal, legal;
  logic [XLEN-1:0] imm, alu_b, alu_res, target, pc_plus4;
  logic [4:0]      shamt;
  logic            taken, rf_we;
  logic [XLEN-1:0] rf_wdata;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  assign is_reg = (opcode == OpReg);
  assign is_imm = (opcode == OpImm);
  assign is_lw  = (opcode == OpLoad);
  assign is_sw  = (opcode == OpStore);
  assign is_br  = (opcode == OpBranch);
  assign is_jal = (opcode == OpJal);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OpReg: begin
        if (f7 == 7'b0000000)      legal = (f3 != 3'b011);
        else if (f7 == 7'b0100000) legal = (f3 == 3'b000);
      end
      OpImm:           legal = (f3 != 3'b001) && (f3 != 3'b011) && (f3 != 3'b101);
      OpLoad, OpStore: legal = (f3 == 3'b010);
      OpBranch:        legal = (f3[2:1] == 2'b00);
      OpJal:           legal = 1'b1;
      default:         legal = 1'b0;
    endcase
  end

  always_comb begin
    imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    if (is_sw) begin
      imm = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    end else if (is_br) begin
      imm = {{(XLEN-12){ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    end else if (is_jal) begin
      imm = {{(XLEN-20){ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
    end
  end

  assign alu_b = is_reg ? b_q : imm_q;
  assign shamt = alu_b[4:0];

  always_comb begin
    case (f3)
      3'b000:  alu_res = (is_reg && f7[5]) ? a_q - alu_b : a_q + alu_b;
      3'b001:  alu_res = a_q << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(alu_b)};
      3'b100:  alu_res = a_q ^ alu_b;
      3'b101:  alu_res = a_q >> shamt;
      3'b110:  alu_res = a_q | alu_b;
      3'b111:  alu_res = a_q & alu_b;
      default: alu_res = a_q + alu_b;
    endcase
  end

  assign target   = pc_q + imm_q;
  assign pc_plus4 = pc_q + XLEN'(4);
  assign taken    = (a_q == b_q) ^ f3[0];
  assign rf_wdata = is_lw ? mdr_q : aluout_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    aluout_d  = aluout_q;
    mdr_d     = mdr_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    unique case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d   = (rs1 == 5'd0) ? '0 : rf_q[rs1];
        b_d   = (rs2 == 5'd0) ? '0 : rf_q[rs2];
        imm_d = imm;
        if (!legal) begin
          trap_d  = TrapIllegal;
          state_d = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (is_lw || is_sw) begin
          aluout_d = a_q + imm_q;
          if (aluout_d[1:0] != 2'b00) begin
            trap_d  = TrapDataAlign;
            state_d = StHalt;
          end else begin
            state_d = StMemory;
          end
        end else if (is_br) begin
          if (taken && target[1:0] != 2'b00) begin
            trap_d  = TrapJumpAlign;
            state_d = StHalt;
          end else begin
            pc_d      = taken ? target : pc_plus4;
            instret_d = instret_q + INSTRET_W'(1);
            state_d   = StFetch;
          end
        end else if (is_jal) begin
          if (target[1:0] != 2'b00) begin
            trap_d  = TrapJumpAlign;
            state_d = StHalt;
          end else begin
            aluout_d = pc_plus4;
            pc_d     = target;
            state_d  = StWriteback;
          end
        end else begin
          aluout_d = alu_res;
          state_d  = StWriteback;
        end
      end
      StMemory: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = aluout_q;
        if (mem_ready) begin
          if (is_sw) begin
            pc_d      = pc_plus4;
            instret_d = instret_q + INSTRET_W'(1);
            state_d   = StFetch;
          end else begin
            mdr_d   = mem_rdata;
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        rf_we     = (rd != 5'd0);
        pc_d      = is_jal ? pc_q : pc_plus4;
        instret_d = instret_q + INSTRET_W'(1);
        state_d   = StFetch;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StHalt;
      end
    endcase
    // Reset is asynchronous, so gate the request combinationally to drop it at once.
    if (reset) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      instret_q <= '0;
      trap_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      aluout_q  <= aluout_d;
      mdr_q     <= mdr_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= rf_wdata;
    end
  end

  assign mem_wdata  = b_q;
  assign pc         = pc_q;
  assign halted     = (state_q == StHalt);
  assign trap_cause = trap_q;
  assign instret    = instret_q;

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multi-cycle RV32I-subset core that supersedes the single-cycle datapath.
- One instruction executes over several states of an FSM and shares a single unified memory port.
- The memory port uses a req/ready handshake, so the core tolerates variable-latency memory.
- Exposes halt, trap and retired-instruction status so benches detect end of program without X-probing.

Parameters:
XLEN, 32, datapath and register width (32 only for RV32; kept parametric for ALU/regfile reuse)
RESET_PC, 32'h0000_0000, PC value loaded on reset
INSTRET_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  XLEN  byte address, word aligned
mem_wdata  out  XLEN  store data
mem_rdata  in  XLEN  read data, valid in the cycle mem_ready=1
mem_ready  in  1  request completes on a rising edge with mem_req=1 and mem_ready=1
pc  out  XLEN  current PC
halted  out  1  core stopped in HALT
trap_cause  out  2  0=none, 1=illegal instr, 2=misaligned data access, 3=misaligned branch/jump target
instret  out  INSTRET_W  count of retired instructions, wraps modulo 2^INSTRET_W

Behaviour:
- Reset is asynchronous and active-high, with one clock, `clk`, and reset port `reset`.
- Reset values: pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, halted=0, trap_cause=0, instret=0. All registers x1..x31 read 0.
- Reset asserted mid-transaction drops mem_req immediately. The in-flight access is abandoned.
- Supported instructions: add, sub, and, or, xor, slt, sll, srl (0110011); addi, andi, ori, xori, slti (0010011); lw (0000011, f3=010); sw (0100011, f3=010); beq, bne (1100011); jal (1101111).
- Anything else is illegal: go to HALT with trap_cause=1.
- x0 reads 0; writes to x0 are dropped.
- Shift amount uses bits [4:0]. slt/slti are signed. All arithmetic wraps mod 2^XLEN.
- FSM states: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold all request signals stable until the handshake. On the handshake, latch IR=mem_rdata and go to DECODE.
- DECODE: read rs1/rs2 into A/B and generate the immediate.
  - Illegal opcode goes to HALT.
- EXECUTE:
  - ALU ops latch ALUOut, then go to WRITEBACK.
  - lw/sw compute addr=rs1+imm. If addr[1:0]!=0, go to HALT with cause 2. Otherwise go to MEMORY.
  - beq/bne: taken branch sets pc=pc+imm, else pc=pc+4. Target[1:0]!=0 on a taken branch goes to HALT with cause 3. Otherwise retire and go to FETCH.
  - jal: ALUOut=pc+4 and pc=pc+imm, with the same target check, then go to WRITEBACK.
- MEMORY: mem_req=1, mem_we=is_sw, mem_wdata=B, held stable until the handshake.
  - sw: on the handshake, retire, pc+=4, go to FETCH.
  - lw: on the handshake, latch MDR and go to WRITEBACK.
- WRITEBACK: rd <= (lw ? MDR : ALUOut). pc+=4 except for jal, where pc was already updated. Retire, go to FETCH.
- Retire means instret+=1 in the same edge as the final state transition.
- With zero-wait memory (mem_ready tied 1), instruction cost is:
  - branch: 3 cycles
  - ALU, jal, sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle on the memory port adds 1.
- HALT is absorbing until reset. halted=1, mem_req=0, pc holds the faulting instruction's address, and no register or memory writes occur.
- An rd=rs1 hazard is impossible because operands are latched in DECODE.
- mem_rdata is ignored when mem_ready=0 or mem_req=0.

Test Plan:
- Reset then release; memory word 0 = addi x1,x0,5, word 1 = illegal 0x00000000 -> after 4+2 cycles: x1=5, halted=1, trap_cause=1, pc=4, instret=1.
- addi x2,x0,-3; addi x3,x0,7; add x4,x2,x3; sub x5,x2,x3; slt x6,x2,x3 -> x4=4, x5=0xFFFFFFF6, x6=1, instret=5 at 20 cycles (mem_ready=1).
- sw x3,8(x0) then lw x7,8(x0) with mem_ready low for 3 cycles on every request -> mem write addr 8 data 7; x7=7; the lw takes 5+6=11 cycles; req signals stable during waits.
- Loop: addi x1,x0,3; loop: addi x1,x1,-1; bne x1,x0,loop; followed by illegal -> taken twice, x1=0, instret=7, halt at pc=12.
- jal x1,8 at pc=0 -> x1=4, pc=8; jal with imm=2 -> halted, trap_cause=3; lw x2,1(x0) -> trap_cause=2, no memory request issued.
- Assert reset during a MEMORY wait of sw -> mem_req drops the same cycle, no write completes, pc=RESET_PC, instret=0; addi x0,x0,9 leaves x0=0.
